// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling engine: width derivation, mode and row-phase encodings,
// and the signed max used by both the horizontal and vertical combine stages.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } row_state_e;

  // Wide enough for any sample this engine is realistically built for; callers sign-extend into it.
  localparam int CMP_W = 64;

  function automatic int data_w(input int integer_bits, input int fixed_point_bits);
    return integer_bits + fixed_point_bits;
  endfunction

  function automatic logic signed [CMP_W-1:0] smax(input logic signed [CMP_W-1:0] a,
                                                   input logic signed [CMP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Half-width row store holding one horizontal pair per 2-column slot of the even row.
// Synchronous write, asynchronous read so the odd row can combine in the accepting cycle.
module pool_row_buffer
  import pool_pkg::*;
#(
  parameter int  DEPTH = 256,
  parameter int  WIDTH = 14,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/pool2x2_stream.sv
// 2x2 stride-2 max/average pooling over a raster pixel stream; one result per window, one cycle
// after the odd-row/odd-column beat. Input stalls only while an unaccepted result is held.
module pool2x2_stream
  import pool_pkg::*;
#(
  parameter int  INTEGER_BITS     = 9,
  parameter int  FIXED_POINT_BITS = 4,
  parameter int  LINE_W           = 512,
  parameter int  N_ROWS           = 512,
  localparam int DATA_W           = data_w(INTEGER_BITS, FIXED_POINT_BITS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_frame_done
);

  localparam int PW    = DATA_W + 1;
  localparam int SW    = DATA_W + 2;
  localparam int COL_W = $clog2(LINE_W);
  localparam int ROW_W = $clog2(N_ROWS);
  localparam int DEPTH = LINE_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

  row_state_e                state_q, state_d;
  pool_mode_e                mode_q, mode_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic signed [PW-1:0]      pair_q, pair_d;
  logic signed [DATA_W-1:0]  data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      last_q, last_d;
  logic                      done_q, done_d;

  logic                      accept;
  logic                      first_beat;
  logic                      col_last;
  logic                      row_last;
  pool_mode_e                mode_eff;
  logic signed [PW-1:0]      cur_ext;
  logic signed [PW-1:0]      hpair;
  logic signed [SW-1:0]      vsum;
  logic signed [DATA_W-1:0]  result;
  logic                      buf_we;
  logic [AW-1:0]             buf_addr;
  logic signed [PW-1:0]      buf_rdata;

  function automatic logic signed [CMP_W-1:0] sext(input logic signed [PW-1:0] v);
    return {{(CMP_W-PW){v[PW-1]}}, v};
  endfunction

  assign o_ready    = !valid_q || i_ready;
  assign accept     = i_valid && o_ready;
  assign first_beat = (row_q == '0) && (col_q == '0);
  assign col_last   = (col_q == COL_LAST);
  assign row_last   = (row_q == ROW_LAST);
  // The first beat of a frame already runs in the mode it presents.
  assign mode_eff   = first_beat ? pool_mode_e'(i_mode) : mode_q;
  assign cur_ext    = {i_data[DATA_W-1], i_data};
  assign buf_addr   = AW'(col_q >> 1);
  assign buf_we     = accept && col_q[0] && (state_q == ROW_EVEN);

  always_comb begin
    hpair  = '0;
    vsum   = '0;
    result = '0;
    if (mode_eff == POOL_MAX) begin
      hpair  = PW'(smax(sext(pair_q), sext(cur_ext)));
      result = DATA_W'(smax(sext(buf_rdata), sext(hpair)));
    end else begin
      hpair  = pair_q + cur_ext;
      vsum   = {buf_rdata[PW-1], buf_rdata} + {hpair[PW-1], hpair};
      result = DATA_W'(vsum >>> 2);
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    col_d   = col_q;
    row_d   = row_q;
    pair_d  = pair_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = valid_q && i_ready && last_q;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      col_d = col_last ? '0 : col_q + COL_W'(1);
      if (col_last) begin
        row_d   = row_last ? '0 : row_q + ROW_W'(1);
        state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
      end
      if (first_beat) begin
        mode_d = pool_mode_e'(i_mode);
      end
      if (!col_q[0]) begin
        pair_d = cur_ext;
      end else if (state_q == ROW_ODD) begin
        // Loading here may coincide with the previous result draining this same cycle.
        valid_d = 1'b1;
        data_d  = result;
        last_d  = row_last && col_last;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ROW_EVEN;
      mode_q  <= POOL_MAX;
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  pool_row_buffer #(
    .DEPTH(DEPTH),
    .WIDTH(PW)
  ) u_row_buffer (
    .i_clk  (i_clk),
    .i_we   (buf_we),
    .i_waddr(buf_addr),
    .i_wdata(hpair),
    .i_raddr(buf_addr),
    .o_rdata(buf_rdata)
  );

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream on a 4x2 frame: directed windows, backpressure, mode latch,
// mid-frame reset and randomized back-to-back frames against a window-level reference model.
module tb_pool2x2_stream;

  localparam int LW = 4;
  localparam int NR = 2;
  localparam int DW = 13;
  localparam int NPIX = LW * NR;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_mode;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic          o_frame_done;

  always #5 clk = ~clk;

  pool2x2_stream #(
    .INTEGER_BITS    (9),
    .FIXED_POINT_BITS(4),
    .LINE_W          (LW),
    .N_ROWS          (NR)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_mode      (i_mode),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_done(o_frame_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int pix [NPIX];
  int exp_val [$];
  bit exp_last [$];
  int rdy_pct = 100;
  bit mon_en = 1'b0;
  int fd_seen = 0;
  int frames_sent = 0;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
    end
  endtask

  // Reference: a window is four pixels; max of them, or the floor of their mean.
  function automatic int pool_ref(input int mode, input int a, input int b, input int c, input int d);
    int s;
    int m;
    if (mode == 0) begin
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
    end
    s = a + b + c + d;
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  task automatic push_exp(input int v, input bit last);
    exp_val.push_back(v);
    exp_last.push_back(last);
  endtask

  task automatic build_expected(input int mode);
    for (int wr = 0; wr < NR / 2; wr++) begin
      for (int wc = 0; wc < LW / 2; wc++) begin
        int base;
        base = 2 * wr * LW + 2 * wc;
        push_exp(pool_ref(mode, pix[base], pix[base + 1], pix[base + LW], pix[base + LW + 1]),
                 (wr == NR / 2 - 1) && (wc == LW / 2 - 1));
      end
    end
  endtask

  task automatic randomize_pix();
    for (int k = 0; k < NPIX; k++) pix[k] = int'($urandom_range(8191)) - 4096;
  endtask

  // Frame mode is presented only on beat 0; every later beat shows the opposite mode.
  task automatic send_frame(input int mode, input int vld_pct, input int n_beats);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < n_beats && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (int'($urandom_range(99)) < vld_pct) begin
        i_valid = 1'b1;
        i_data  = DW'(pix[idx]);
      end else begin
        i_valid = 1'b0;
        i_data  = DW'($urandom);
      end
      i_mode = (idx == 0) ? mode[0] : ~mode[0];
      #4;
      if (i_valid && o_ready) idx++;
    end
    check_eq("beats_accepted", idx, n_beats);
    if (n_beats == NPIX) frames_sent++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_data  = DW'($urandom);
    end
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (exp_val.size() != 0 && cyc < 500) begin
      @(negedge clk);
      i_valid = 1'b0;
      cyc++;
    end
    idle(2);
    check_eq("drain_empty", exp_val.size(), 0);
  endtask

  // Output side: randomized i_ready, handshake scoreboard, hold stability, frame_done timing.
  initial begin
    bit hold_chk;
    int hold_data;
    bit fd_exp;
    hold_chk = 1'b0;
    hold_data = 0;
    fd_exp = 1'b0;
    forever begin
      @(negedge clk);
      i_ready = (int'($urandom_range(99)) < rdy_pct);
      #4;
      if (mon_en) begin
        check_eq("o_ready_rule", o_ready, (!o_valid || i_ready));
        check_eq("frame_done", o_frame_done, fd_exp);
        if (o_frame_done) fd_seen++;
        if (hold_chk) begin
          check_eq("hold_valid", o_valid, 1);
          check_eq("hold_data", $signed(o_data), hold_data);
        end
        fd_exp = 1'b0;
        if (o_valid && i_ready) begin
          check_eq("result_expected", exp_val.size() > 0, 1);
          if (exp_val.size() > 0) begin
            check_eq("pool_out", $signed(o_data), exp_val[0]);
            fd_exp = exp_last[0];
            void'(exp_val.pop_front());
            void'(exp_last.pop_front());
          end
        end
        hold_chk  = o_valid && !i_ready;
        hold_data = $signed(o_data);
      end else begin
        hold_chk = 1'b0;
        fd_exp   = 1'b0;
      end
    end
  end

  initial begin
    int m;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_mode  = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = DW'($urandom);
      #4;
      check_eq("rst_valid", o_valid, 0);
      check_eq("rst_ready", o_ready, 1);
      check_eq("rst_frame_done", o_frame_done, 0);
    end
    @(negedge clk);
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    mon_en  = 1'b1;

    pix = '{1, 5, -3, 2, 4, -8, 7, 0};
    push_exp(5, 1'b0);
    push_exp(7, 1'b1);
    send_frame(0, 100, NPIX);
    wait_drain();
    check_eq("fd_after_max", fd_seen, 1);

    pix = '{-1, -1, 3, 4, -1, -2, 1, 1};
    push_exp(-2, 1'b0);
    push_exp(2, 1'b1);
    send_frame(1, 100, NPIX);
    for (int k = 0; k < NPIX; k++) pix[k] = 4095;
    push_exp(4095, 1'b0);
    push_exp(4095, 1'b1);
    send_frame(1, 100, NPIX);
    for (int k = 0; k < NPIX; k++) pix[k] = -4096;
    push_exp(-4096, 1'b0);
    push_exp(-4096, 1'b1);
    send_frame(1, 100, NPIX);
    wait_drain();

    randomize_pix();
    build_expected(0);
    rdy_pct = 0;
    fork
      send_frame(0, 100, NPIX);
      begin
        int c;
        c = 0;
        while (c < 100) begin
          @(negedge clk);
          #4;
          c++;
          if (o_valid) break;
        end
        check_eq("bp_valid_seen", o_valid, 1);
        repeat (5) begin
          @(negedge clk);
          #4;
          check_eq("bp_ready_low", o_ready, 0);
        end
        rdy_pct = 100;
      end
    join
    wait_drain();

    for (int f = 0; f < 4; f++) begin
      randomize_pix();
      build_expected(f % 2);
      send_frame(f % 2, 100, NPIX);
    end
    wait_drain();

    randomize_pix();
    rdy_pct = 0;
    send_frame(1, 100, 6);
    idle(2);
    #4;
    check_eq("rst_mid_pending", o_valid, 1);
    @(negedge clk);
    i_rst_n = 1'b0;
    mon_en  = 1'b0;
    @(negedge clk);
    #4;
    check_eq("rst_mid_drop", o_valid, 0);
    check_eq("rst_mid_ready", o_ready, 1);
    @(negedge clk);
    i_rst_n = 1'b1;
    exp_val.delete();
    exp_last.delete();
    rdy_pct = 100;
    mon_en  = 1'b1;
    randomize_pix();
    build_expected(0);
    send_frame(0, 100, NPIX);
    wait_drain();

    for (int f = 0; f < 60; f++) begin
      randomize_pix();
      m = int'($urandom_range(1));
      rdy_pct = int'($urandom_range(100, 30));
      build_expected(m);
      send_frame(m, int'($urandom_range(100, 30)), NPIX);
    end
    rdy_pct = 100;
    wait_drain();
    check_eq("frames_done", fd_seen, frames_sent);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
